// File: rtl/arya_dispatch_pkg.sv
// arya_dispatch_pkg: dispatcher FSM encoding and default widths shared with the output arbiter
package arya_dispatch_pkg;
  localparam int NUM_THREADS_DEF = 4;
  localparam int DATAPATH_WIDTH_DEF = 64;
  localparam int CTRL_WIDTH_DEF = 8;
  localparam int THREAD_BITS_DEF = 2;
  typedef enum logic [1:0] {WAIT, READY, HDR, PAYLOAD} state_t;
endpackage

// File: rtl/thread_busy_tracker.sv
// thread_busy_tracker: one thread's busy flag; set on packet start, cleared by release, set wins
// ports: clk, reset (sync, active-high), set, clr, busy
module thread_busy_tracker (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic busy
);
  always_ff @(posedge clk)
    busy <= reset ? 1'b0 : set ? 1'b1 : clr ? 1'b0 : busy;
endmodule

// File: rtl/infifo_dispatcher.sv
// infifo_dispatcher: round-robin whole-packet dispatch of the input stream to worker threads
// ports: clk, reset (sync, active-high); in_data/in_ctrl/in_wr/in_rdy input stream;
//   thread_nearly_full, thread_release per-thread status; out_data/out_ctrl broadcast word,
//   out_wr one-hot strobe, pkt_start first-word pulse; thread_busy, cur_thread, drop_err status
module infifo_dispatcher
  import arya_dispatch_pkg::*;
#(
  parameter int NUM_THREADS = NUM_THREADS_DEF,
  parameter int DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int THREAD_BITS = THREAD_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATAPATH_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  input  logic                      in_wr,
  output logic                      in_rdy,
  input  logic [NUM_THREADS-1:0]    thread_nearly_full,
  input  logic [NUM_THREADS-1:0]    thread_release,
  output logic [DATAPATH_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic [NUM_THREADS-1:0]    out_wr,
  output logic [NUM_THREADS-1:0]    pkt_start,
  output logic [NUM_THREADS-1:0]    thread_busy,
  output logic [THREAD_BITS-1:0]    cur_thread,
  output logic                      drop_err
);
  state_t state, state_nx;
  logic accept, eop;
  logic [NUM_THREADS-1:0] sel;
  // in_rdy depends only on registered state and the thread's fullness, never on in_wr
  assign in_rdy = state != WAIT && !thread_nearly_full[cur_thread];
  assign accept = in_wr && in_rdy;
  assign eop = accept && state == PAYLOAD && in_ctrl != '0;
  assign sel = NUM_THREADS'(1) << cur_thread;
  always_ff @(posedge clk)
    state <= reset ? READY : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      WAIT:    if (!thread_busy[cur_thread]) state_nx = READY;
      READY:   if (accept) state_nx = in_ctrl != '0 ? HDR : PAYLOAD;
      HDR:     if (accept && in_ctrl == '0) state_nx = PAYLOAD;
      PAYLOAD: if (eop) state_nx = WAIT;
      default: state_nx = READY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_thread <= '0;
      out_wr <= '0;
      pkt_start <= '0;
      out_data <= '0;
      out_ctrl <= '0;
      drop_err <= 1'b0;
    end else begin
      if (eop) cur_thread <= cur_thread == THREAD_BITS'(NUM_THREADS - 1) ? '0 : cur_thread + THREAD_BITS'(1);
      out_wr <= accept ? sel : '0;
      pkt_start <= accept && state == READY ? sel : '0;
      if (accept) begin
        out_data <= in_data;
        out_ctrl <= in_ctrl;
      end
      drop_err <= drop_err || (in_wr && !in_rdy);
    end
  end
  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_busy
    thread_busy_tracker u_trk (
      .clk  (clk),
      .reset(reset),
      .set  (accept && state == READY && cur_thread == THREAD_BITS'(i)),
      .clr  (thread_release[i]),
      .busy (thread_busy[i])
    );
  end
endmodule
